// File: rtl/result_bcd_formatter.sv
// Signed binary result to three-digit BCD formatter for the seven-segment driver.
// Iterative double-dabble; outputs hold until the next conversion finishes.
module result_bcd_formatter #(
  parameter int WIDTH       = 16,
  parameter int DIGITS_BITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             err_in,
  output logic             busy,
  output logic             done,
  output logic [11:0]      display,
  output logic             neg,
  output logic             nothing
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]       value_q;
  logic                   err_q;
  logic                   neg_pend_q;
  logic [DIGITS_BITS-1:0] shift_q;
  logic [11:0]            bcd_q;
  logic [3:0]             count_q;

  logic [WIDTH-1:0]       magnitude;
  logic                   overflow;
  logic [11:0]            bcd_adj;
  logic [11:0]            bcd_shifted;
  logic [DIGITS_BITS-1:0] shift_shifted;
  logic                   last_shift;

  // Unsigned WIDTH-bit absolute value: the most negative input maps to 2^(WIDTH-1).
  always_comb begin
    magnitude = value_q;
    if (value_q[WIDTH-1]) begin
      magnitude = (~value_q) + WIDTH'(1);
    end
  end

  assign overflow   = err_q || (magnitude > WIDTH'(999));
  assign last_shift = (count_q == 4'(DIGITS_BITS - 1));

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Top BCD bit drops off the shift; magnitude never exceeds 999 here.
  assign {bcd_shifted, shift_shifted} = {bcd_adj[10:0], shift_q, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = overflow ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= '0;
      err_q      <= 1'b0;
      neg_pend_q <= 1'b0;
      shift_q    <= '0;
      bcd_q      <= '0;
      count_q    <= '0;
      display    <= '0;
      neg        <= 1'b0;
      nothing    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            value_q <= value;
            err_q   <= err_in;
          end
        end
        LOAD: begin
          if (overflow) begin
            display <= '0;
            neg     <= 1'b0;
            nothing <= 1'b1;
          end else begin
            shift_q    <= magnitude[DIGITS_BITS-1:0];
            bcd_q      <= '0;
            count_q    <= '0;
            neg_pend_q <= value_q[WIDTH-1] && (magnitude != '0);
          end
        end
        SHIFT: begin
          bcd_q   <= bcd_shifted;
          shift_q <= shift_shifted;
          count_q <= count_q + 4'd1;
          if (last_shift) begin
            display <= bcd_shifted;
            neg     <= neg_pend_q;
            nothing <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Directed self-checking bench for result_bcd_formatter.
module tb_result_bcd_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        err_in = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] display;
  logic        neg;
  logic        nothing;

  int tests = 0;
  int failed = 0;

  result_bcd_formatter #(.WIDTH(16), .DIGITS_BITS(10)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .err_in(err_in),
    .busy(busy), .done(done), .display(display), .neg(neg), .nothing(nothing)
  );

  always #5 clk = ~clk;

  // Pulses start, then counts edges until done (bounded at 40).
  task automatic do_conv(input logic [15:0] v, input logic e,
                         output int lat, output int bsy, output int both);
    @(negedge clk);
    value = v; err_in = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bsy = busy ? 1 : 0;
    lat = 0; both = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy && done) both++;
      if (done) break;
      if (busy) bsy++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (display !== 12'h000) begin failed++; $display("FAIL reset_display got %h want 000", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL reset_neg got %b want 0", neg); end
    tests++; if (nothing !== 1'b1) begin failed++; $display("FAIL reset_nothing got %b want 1", nothing); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_convert;
    int lat, bsy, both;
    do_conv(16'd123, 1'b0, lat, bsy, both);
    tests++; if (lat !== 11) begin failed++; $display("FAIL p123_latency got %0d want 11", lat); end
    tests++; if (bsy !== 11) begin failed++; $display("FAIL p123_busy_cycles got %0d want 11", bsy); end
    tests++; if (both !== 0) begin failed++; $display("FAIL p123_busy_with_done got %0d want 0", both); end
    tests++; if (display !== 12'h123) begin failed++; $display("FAIL p123_display got %h want 123", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL p123_neg got %b want 0", neg); end
    tests++; if (nothing !== 1'b0) begin failed++; $display("FAIL p123_nothing got %b want 0", nothing); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL p123_done_width got %b want 0", done); end
    tests++; if (display !== 12'h123) begin failed++; $display("FAIL p123_hold got %h want 123", display); end

    do_conv(-16'sd457, 1'b0, lat, bsy, both);
    tests++; if (lat !== 11) begin failed++; $display("FAIL n457_latency got %0d want 11", lat); end
    tests++; if (display !== 12'h457) begin failed++; $display("FAIL n457_display got %h want 457", display); end
    tests++; if (neg !== 1'b1) begin failed++; $display("FAIL n457_neg got %b want 1", neg); end
    tests++; if (nothing !== 1'b0) begin failed++; $display("FAIL n457_nothing got %b want 0", nothing); end

    do_conv(16'd0, 1'b0, lat, bsy, both);
    tests++; if (display !== 12'h000) begin failed++; $display("FAIL zero_display got %h want 000", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL zero_neg got %b want 0", neg); end
    tests++; if (nothing !== 1'b0) begin failed++; $display("FAIL zero_nothing got %b want 0", nothing); end
  endtask

  task automatic test_bounds;
    int lat, bsy, both;
    do_conv(16'd999, 1'b0, lat, bsy, both);
    tests++; if (display !== 12'h999) begin failed++; $display("FAIL p999_display got %h want 999", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL p999_neg got %b want 0", neg); end

    do_conv(-16'sd999, 1'b0, lat, bsy, both);
    tests++; if (display !== 12'h999) begin failed++; $display("FAIL n999_display got %h want 999", display); end
    tests++; if (neg !== 1'b1) begin failed++; $display("FAIL n999_neg got %b want 1", neg); end

    do_conv(16'd1000, 1'b0, lat, bsy, both);
    tests++; if (lat !== 1) begin failed++; $display("FAIL p1000_latency got %0d want 1", lat); end
    tests++; if (bsy !== 1) begin failed++; $display("FAIL p1000_busy_cycles got %0d want 1", bsy); end
    tests++; if (nothing !== 1'b1) begin failed++; $display("FAIL p1000_nothing got %b want 1", nothing); end
    tests++; if (display !== 12'h000) begin failed++; $display("FAIL p1000_display got %h want 000", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL p1000_neg got %b want 0", neg); end

    do_conv(16'd7, 1'b0, lat, bsy, both);
    tests++; if (display !== 12'h007) begin failed++; $display("FAIL p7_display got %h want 007", display); end

    do_conv(16'h8000, 1'b0, lat, bsy, both);
    tests++; if (lat !== 1) begin failed++; $display("FAIL min_latency got %0d want 1", lat); end
    tests++; if (nothing !== 1'b1) begin failed++; $display("FAIL min_nothing got %b want 1", nothing); end
    tests++; if (display !== 12'h000) begin failed++; $display("FAIL min_display got %h want 000", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL min_neg got %b want 0", neg); end

    do_conv(16'd42, 1'b0, lat, bsy, both);
    do_conv(16'd5, 1'b1, lat, bsy, both);
    tests++; if (lat !== 1) begin failed++; $display("FAIL err_latency got %0d want 1", lat); end
    tests++; if (nothing !== 1'b1) begin failed++; $display("FAIL err_nothing got %b want 1", nothing); end
    tests++; if (display !== 12'h000) begin failed++; $display("FAIL err_display got %h want 000", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL err_neg got %b want 0", neg); end
  endtask

  task automatic test_busy_start_reset;
    int lat, dones;
    // Accepted start of 321, then start held high with another value while busy.
    @(negedge clk);
    value = 16'd321; err_in = 1'b0; start = 1'b1;
    @(negedge clk);
    value = 16'd777;
    lat = 0; dones = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) begin dones++; break; end
    end
    start = 1'b0;
    tests++; if (lat !== 11) begin failed++; $display("FAIL busy_start_latency got %0d want 11", lat); end
    tests++; if (display !== 12'h321) begin failed++; $display("FAIL busy_start_display got %h want 321", display); end
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    tests++; if (dones !== 1) begin failed++; $display("FAIL busy_start_dones got %0d want 1", dones); end

    // Reset sampled at the edge ending the 5th SHIFT cycle.
    @(negedge clk);
    value = 16'd654; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL shift5_busy got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (display !== 12'h000) begin failed++; $display("FAIL midreset_display got %h want 000", display); end
    tests++; if (neg !== 1'b0) begin failed++; $display("FAIL midreset_neg got %b want 0", neg); end
    tests++; if (nothing !== 1'b1) begin failed++; $display("FAIL midreset_nothing got %b want 1", nothing); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL midreset_busy got %b want 0", busy); end
    dones = 0;
    repeat (15) begin
      if (done) dones++;
      @(negedge clk);
    end
    tests++; if (dones !== 0) begin failed++; $display("FAIL midreset_dones got %0d want 0", dones); end

    begin
      int bsy, both;
      do_conv(-16'sd88, 1'b0, lat, bsy, both);
      tests++; if (lat !== 11) begin failed++; $display("FAIL after_reset_latency got %0d want 11", lat); end
      tests++; if (display !== 12'h088) begin failed++; $display("FAIL after_reset_display got %h want 088", display); end
      tests++; if (neg !== 1'b1) begin failed++; $display("FAIL after_reset_neg got %b want 1", neg); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bsy, both, holds;
    do_conv(16'd123, 1'b0, lat, bsy, both);
    tests++; if (display !== 12'h123) begin failed++; $display("FAIL b2b_first_display got %h want 123", display); end
    // Next negedge is the first IDLE cycle.
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done); end
    value = -16'sd45; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; holds = 0;
    while (lat < 40) begin
      if (!done && (display !== 12'h123 || neg !== 1'b0 || nothing !== 1'b0)) holds++;
      if (done) break;
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== 11) begin failed++; $display("FAIL b2b_latency got %0d want 11", lat); end
    tests++; if (holds !== 0) begin failed++; $display("FAIL b2b_hold got %0d changed cycles want 0", holds); end
    tests++; if (display !== 12'h045) begin failed++; $display("FAIL b2b_second_display got %h want 045", display); end
    tests++; if (neg !== 1'b1) begin failed++; $display("FAIL b2b_second_neg got %b want 1", neg); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_bounds();
    test_busy_start_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
